// File: rtl/regfile_sb_if.sv
// Register-file bus for regfile_sb: write ports, read ports, issue, debug and busy count.
// master = core pipeline side, slave = register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wen0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              wen1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W:0]   busy_cnt;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        output raddr1, raddr2, iss_valid, iss_rd, dbg_addr,
        input  rdata1, rdata2, rs1_busy, rs2_busy, busy_cnt, dbg_data
    );

    modport slave (
        input  wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        input  raddr1, raddr2, iss_valid, iss_rd, dbg_addr,
        output rdata1, rdata2, rs1_busy, rs2_busy, busy_cnt, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two read / two write ports, optional write-to-read bypass,
// and a per-register busy scoreboard (set by issue, cleared by writeback; issue wins).
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // One-hot select of a nonzero index; index 0 never produces a bit.
    function automatic logic [NREGS-1:0] decode(input logic en, input logic [ADDR_W-1:0] a);
        return (en && (a != '0)) ? ({{(NREGS-1){1'b0}}, 1'b1} << a) : '0;
    endfunction

    function automatic logic wr_hit(input logic en, input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] ra);
        return en && (wa == ra) && (ra != '0) && (BYPASS != 0);
    endfunction

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  busy_r;
    logic [NREGS-1:0]  busy_nxt_s;
    logic [NREGS-1:0]  clr_s;
    logic [NREGS-1:0]  set_s;
    logic [ADDR_W:0]   busy_cnt_r;
    logic              hit11_s, hit01_s, hit12_s, hit02_s;
    logic [DATA_W-1:0] st1_s, st2_s;

    // Next busy vector: writebacks clear, issue sets afterwards so it wins a collision.
    always_comb begin
        clr_s      = decode(bus.wen0, bus.waddr0) | decode(bus.wen1, bus.waddr1);
        set_s      = decode(bus.iss_valid, bus.iss_rd);
        busy_nxt_s = (busy_r & ~clr_s) | set_s;
    end

    // Register storage; port 1 is written last so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (bus.wen0 && (bus.waddr0 != '0)) begin
                regs_r[bus.waddr0] <= bus.wdata0;
            end
            if (bus.wen1 && (bus.waddr1 != '0)) begin
                regs_r[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // Busy scoreboard and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    // Read ports: optional bypass of same-cycle writebacks, port 1 first.
    always_comb begin
        st1_s   = (bus.raddr1 == '0) ? '0 : regs_r[bus.raddr1];
        st2_s   = (bus.raddr2 == '0) ? '0 : regs_r[bus.raddr2];
        hit11_s = wr_hit(bus.wen1, bus.waddr1, bus.raddr1);
        hit01_s = wr_hit(bus.wen0, bus.waddr0, bus.raddr1);
        hit12_s = wr_hit(bus.wen1, bus.waddr1, bus.raddr2);
        hit02_s = wr_hit(bus.wen0, bus.waddr0, bus.raddr2);
    end

    assign bus.rdata1   = hit11_s ? bus.wdata1 : (hit01_s ? bus.wdata0 : st1_s);
    assign bus.rdata2   = hit12_s ? bus.wdata1 : (hit02_s ? bus.wdata0 : st2_s);
    assign bus.rs1_busy = busy_r[bus.raddr1] & ~(hit11_s | hit01_s);
    assign bus.rs2_busy = busy_r[bus.raddr2] & ~(hit12_s | hit02_s);
    assign bus.busy_cnt = busy_cnt_r;
    assign bus.dbg_data = regs_r[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one bypassed and one non-bypassed instance share stimulus;
// expectations are queued per cycle and a negedge monitor pops and compares them.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam int S_RD1 = 0;
    localparam int S_RD2 = 1;
    localparam int S_RS1 = 2;
    localparam int S_RS2 = 3;
    localparam int S_CNT = 4;
    localparam int S_DBG = 5;
    localparam int S_B0  = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          wen0, wen1, iss_valid;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2, iss_rd, dbg_addr;
    logic [DW-1:0] wdata0, wdata1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    bit   done = 1'b0;
    exp_t q[$];

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) ifb1 ();
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) ifb0 ();

    assign ifb1.wen0 = wen0;       assign ifb0.wen0 = wen0;
    assign ifb1.waddr0 = waddr0;   assign ifb0.waddr0 = waddr0;
    assign ifb1.wdata0 = wdata0;   assign ifb0.wdata0 = wdata0;
    assign ifb1.wen1 = wen1;       assign ifb0.wen1 = wen1;
    assign ifb1.waddr1 = waddr1;   assign ifb0.waddr1 = waddr1;
    assign ifb1.wdata1 = wdata1;   assign ifb0.wdata1 = wdata1;
    assign ifb1.raddr1 = raddr1;   assign ifb0.raddr1 = raddr1;
    assign ifb1.raddr2 = raddr2;   assign ifb0.raddr2 = raddr2;
    assign ifb1.iss_valid = iss_valid; assign ifb0.iss_valid = iss_valid;
    assign ifb1.iss_rd = iss_rd;   assign ifb0.iss_rd = iss_rd;
    assign ifb1.dbg_addr = dbg_addr; assign ifb0.dbg_addr = dbg_addr;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_b1 (.clk(clk), .rst(rst), .bus(ifb1));
    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_b0 (.clk(clk), .rst(rst), .bus(ifb0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_RD1:        return ifb1.rdata1;
            S_RD2:        return ifb1.rdata2;
            S_RS1:        return {31'd0, ifb1.rs1_busy};
            S_RS2:        return {31'd0, ifb1.rs2_busy};
            S_CNT:        return {26'd0, ifb1.busy_cnt};
            S_DBG:        return ifb1.dbg_data;
            S_B0 + S_RD1: return ifb0.rdata1;
            S_B0 + S_RD2: return ifb0.rdata2;
            S_B0 + S_RS1: return {31'd0, ifb0.rs1_busy};
            S_B0 + S_RS2: return {31'd0, ifb0.rs2_busy};
            S_B0 + S_CNT: return {26'd0, ifb0.busy_cnt};
            S_B0 + S_DBG: return ifb0.dbg_data;
            default:      return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle and compare against the DUT.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_miss++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = actual(e.sel);
                if (act !== e.exp) begin
                    n_miss++;
                    $display("FAIL %s.%s @cyc %0d: got %h, expected %h",
                             (e.sel >= S_B0) ? "b0" : "b1", e.name, cyc, act, e.exp);
                end
            end
        end
        if (done && q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations never checked", q.size());
            q.delete();
        end
    end

    task automatic chk(string name, int sel, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        e.cyc  = cyc;
        q.push_back(e);
    endtask

    task automatic both(string name, int sel, logic [31:0] v);
        chk(name, sel, v);
        chk(name, sel + S_B0, v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        raddr1 = 5'd5; raddr2 = 5'd31; dbg_addr = 5'd7;
        both("rst_rd1", S_RD1, 32'h0); both("rst_rd2", S_RD2, 32'h0);
        both("rst_dbg", S_DBG, 32'h0); both("rst_rs1", S_RS1, 32'h0);
        both("rst_rs2", S_RS2, 32'h0); both("rst_cnt", S_CNT, 32'h0);
        tick();

        // Dual write to x3: port 1 wins; bypass only on b1
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1111_1111;
        wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h2222_2222;
        raddr1 = 5'd3; raddr2 = 5'd5;
        chk("byp_rd1", S_RD1, 32'h2222_2222);
        chk("byp_rd1", S_B0 + S_RD1, 32'h0);
        both("byp_rd2", S_RD2, 32'h0);
        tick();
        idle();
        dbg_addr = 5'd3;
        both("wr_rd1", S_RD1, 32'h2222_2222);
        both("wr_dbg", S_DBG, 32'h2222_2222);
        tick();

        // x0 immunity
        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        both("x0_rd1", S_RD1, 32'h0); both("x0_rs1", S_RS1, 32'h0);
        both("x0_cnt", S_CNT, 32'h0);
        tick();
        idle();
        dbg_addr = 5'd0;
        both("x0_rd1n", S_RD1, 32'h0); both("x0_rs1n", S_RS1, 32'h0);
        both("x0_cntn", S_CNT, 32'h0); both("x0_dbg", S_DBG, 32'h0);
        tick();

        // Scoreboard: issue x4 then x9
        iss_valid = 1'b1; iss_rd = 5'd4; raddr1 = 5'd4;
        both("iss4_rs1", S_RS1, 32'h0); both("iss4_cnt", S_CNT, 32'h0);
        tick();
        iss_rd = 5'd9; raddr2 = 5'd9;
        both("iss9_rs1", S_RS1, 32'h1); both("iss9_rs2", S_RS2, 32'h0);
        both("iss9_cnt", S_CNT, 32'h1);
        tick();
        idle();
        wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_0044;
        chk("wb4_rs1", S_RS1, 32'h0); chk("wb4_rs1", S_B0 + S_RS1, 32'h1);
        chk("wb4_rd1", S_RD1, 32'h44); chk("wb4_rd1", S_B0 + S_RD1, 32'h0);
        both("wb4_rs2", S_RS2, 32'h1); both("wb4_cnt", S_CNT, 32'h2);
        tick();
        idle();
        both("wb4n_rs1", S_RS1, 32'h0); both("wb4n_rd1", S_RD1, 32'h44);
        both("wb4n_rs2", S_RS2, 32'h1); both("wb4n_cnt", S_CNT, 32'h1);
        tick();

        // Issue/writeback collision on x6
        iss_valid = 1'b1; iss_rd = 5'd6;
        both("pre6_cnt", S_CNT, 32'h1);
        tick();
        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h0000_0055; raddr1 = 5'd6;
        both("col_cnt", S_CNT, 32'h2);
        chk("col_rs1", S_RS1, 32'h0); chk("col_rs1", S_B0 + S_RS1, 32'h1);
        chk("col_rd1", S_RD1, 32'h55); chk("col_rd1", S_B0 + S_RD1, 32'h0);
        tick();
        idle();
        dbg_addr = 5'd6;
        both("coln_rd1", S_RD1, 32'h55); both("coln_rs1", S_RS1, 32'h1);
        both("coln_cnt", S_CNT, 32'h2); both("coln_dbg", S_DBG, 32'h55);
        tick();

        // Reset mid-operation with x1..x10 busy
        for (int i = 1; i <= 10; i++) begin
            iss_valid = 1'b1;
            iss_rd = AW'(i);
            tick();
        end
        idle();
        rst = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd7;
        wen1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0000_ABCD;
        raddr1 = 5'd10; raddr2 = 5'd1;
        both("mid_cnt", S_CNT, 32'd10); both("mid_rs1", S_RS1, 32'h1);
        both("mid_rs2", S_RS2, 32'h1);
        tick();
        rst = 1'b0;
        idle();
        raddr1 = 5'd12; raddr2 = 5'd7; dbg_addr = 5'd12;
        both("post_cnt", S_CNT, 32'h0); both("post_rd1", S_RD1, 32'h0);
        both("post_dbg", S_DBG, 32'h0); both("post_rs1", S_RS1, 32'h0);
        both("post_rs2", S_RS2, 32'h0);
        tick();
        raddr1 = 5'd4; raddr2 = 5'd6;
        both("post_x4", S_RD1, 32'h0); both("post_x6", S_RD2, 32'h0);
        tick();

        tick();
        done = 1'b1;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded integer register file for the pipelined RV32 core. It provides two combinational read ports with optional same-cycle write-to-read bypass and two write ports with fixed priority. It also keeps a per-register busy scoreboard that decode sets and writeback clears. It sits between ID (reads, issue) and WB (writes), and exposes a debug read port and a busy count for stall logic and VGA debug.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W registers, index 0 hard-wired to zero
- BYPASS, 1, 1 = reads and busy flags see same-cycle writebacks; 0 = they see only stored state

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wen0  in  1  write enable, port 0 (lower priority)
- waddr0  in  ADDR_W  write index, port 0
- wdata0  in  DATA_W  write data, port 0
- wen1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write index, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr1, raddr2  in  ADDR_W  read indices
- rdata1, rdata2  out  DATA_W  read data, combinational
- rs1_busy, rs2_busy  out  1  busy flag of raddr1/raddr2, combinational
- iss_valid  in  1  issue: mark iss_rd busy
- iss_rd  in  ADDR_W  destination register being issued
- busy_cnt  out  ADDR_W+1  registered count of busy registers
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  stored value at dbg_addr, never bypassed

## Operation
- Storage: regs[1..NREGS-1] of DATA_W bits; busy[1..NREGS-1] of 1 bit each. Index 0 always reads 0 and busy 0. Writes or issues to index 0 are ignored.
- Write, per port p: if wen_p and waddr_p != 0, then regs[waddr_p] <= wdata_p and busy[waddr_p] is cleared.
- Both write ports hit the same nonzero index: port 1 data is stored; busy is cleared once.
- Issue: if iss_valid and iss_rd != 0, then busy[iss_rd] <= 1.
- Issue and writeback hit the same index in the same cycle: the write data is stored and busy ends at 1, because issue wins for the new producer.
- Read with BYPASS=1:
  - if wen1 and waddr1 == raddr and raddr != 0, rdata = wdata1;
  - else if wen0 and waddr0 == raddr and raddr != 0, rdata = wdata0;
  - else rdata = regs[raddr].
- Read with BYPASS=0: rdata = regs[raddr], or 0 for index 0.
- Busy flag: rs_busy = busy[raddr]. With BYPASS=1 it is forced to 0 when either write port is enabled and writing raddr this cycle. A same-cycle issue never affects rs_busy.
- busy_cnt: number of set busy bits in the state after each clock edge. It is the registered popcount of the next-state busy vector, so it always equals the current busy bit count. Range is 0..NREGS-1.

## Timing
- Reset: when rst=1 at a clock edge, all regs go to 0, all busy bits go to 0, and busy_cnt goes to 0.
- Writes and issues presented in a reset cycle are dropped. Reset asserted mid-operation discards every pending busy bit.
- After reset, before any write, every read port and dbg_data return 0 and every busy flag is 0.
- Write latency: with BYPASS=1, data is visible on read ports in the same cycle and in storage and dbg_data from the next cycle. With BYPASS=0, it is visible from the next cycle only.
- Issue latency: busy is visible on rs_busy one cycle after iss_valid. busy_cnt updates on the same edge as busy.
- No handshake: every request is accepted in the cycle it is presented, and there is no backpressure.

## Test plan
- Reset then read: assert rst for 2 cycles, then set raddr1=5, raddr2=31, dbg_addr=7 -> rdata1=rdata2=dbg_data=0, rs1_busy=rs2_busy=0, busy_cnt=0.
- Bypass and priority: BYPASS=1; in one cycle set wen0 with waddr0=3, wdata0=0x11111111, set wen1 with waddr1=3, wdata1=0x22222222, and raddr1=3 -> rdata1=0x22222222 that cycle, and dbg_data(3)=0x22222222 on the next cycle. BYPASS=0 with the same stimulus -> rdata1 shows the old value that cycle and 0x22222222 on the next.
- x0 immunity: wen1 with waddr1=0, wdata1=0xDEADBEEF, plus iss_valid with iss_rd=0 -> rdata(0)=0, busy(0)=0, busy_cnt unchanged.
- Scoreboard: issue to x4 then x9 on consecutive cycles -> busy_cnt reads 1 then 2. Write x4 with raddr1=4 and BYPASS=1 -> rs1_busy=0 in the same cycle, busy_cnt=1 on the next.
- Issue/writeback collision: in one cycle set iss_valid with iss_rd=6 and wen0 with waddr0=6, wdata0=0x55 while x6 is busy -> next cycle regs[6]=0x55, rs_busy(6)=1, busy_cnt unchanged.
- Reset mid-operation: mark x1..x10 busy so busy_cnt=10, then assert rst together with iss_valid and wen1 -> next cycle all busy bits are 0, busy_cnt=0, and the reset-cycle write is not stored.
